// File: rtl/pc_sequencer_if.sv
// Control-side bundle of the PC sequencer: PC register feedback, fetch handshake,
// redirect requests and the interrupt/return-stack status outputs.
interface pc_sequencer_if;
  logic [15:0] pc_cur;
  logic [15:0] pc_next;
  logic        imem_req;
  logic        imem_ready;
  logic        stall;
  logic        branch_taken;
  logic        jump;
  logic        call;
  logic        ret;
  logic [15:0] target;
  logic        irq;
  logic        eret;
  logic        halt;
  logic        irq_ack;
  logic [15:0] epc;
  logic        ras_err;

  // master: the sequencer itself; slave: the PC register / execute-stage side
  modport master (
    input  pc_cur, imem_ready, stall, branch_taken, jump, call, ret, target,
           irq, eret, halt,
    output pc_next, imem_req, irq_ack, epc, ras_err
  );

  modport slave (
    output pc_cur, imem_ready, stall, branch_taken, jump, call, ret, target,
           irq, eret, halt,
    input  pc_next, imem_req, irq_ack, epc, ras_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC selection: sequential fetch, branch/jump, call/return via a circular
// return-address stack, interrupt entry/return, stall and halt.
module pc_sequencer #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter logic [15:0] IRQ_VECTOR   = 16'h0010,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input logic          clk,
  input logic          reset,
  pc_sequencer_if.master bus
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] RAS_FULL = (PW+1)'(RAS_DEPTH);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALTED} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_int_en;
  logic [15:0]   r_epc;
  logic [15:0]   r_ras [RAS_DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW:0]   r_cnt;
  logic          r_ras_err;

  logic [15:0]   w_pc_inc, w_seq, w_base, w_top, w_pc_next, w_epc_d;
  logic [PW-1:0] w_top_idx;
  logic          w_ras_empty, w_ras_full, w_irq_take;
  logic          w_push_c, w_pop_c, w_err_c, w_ie_set_c;
  logic          w_push, w_pop, w_err_set, w_ie_set, w_ie_clr, w_epc_ld;
  logic          w_imem_req, w_irq_ack;

  assign w_pc_inc    = bus.pc_cur + 16'd1;
  assign w_ras_empty = (r_cnt == '0);
  assign w_ras_full  = (r_cnt == RAS_FULL);
  // r_wp points at the next free slot; the top of stack sits one below it
  assign w_top_idx   = r_wp - {{(PW-1){1'b0}}, 1'b1};
  assign w_top       = r_ras[w_top_idx];
  assign w_irq_take  = bus.irq & r_int_en;

  // Address the non-interrupt rules select; also the EPC captured on irq entry
  always_comb begin : base_sel
    w_seq      = (bus.imem_ready && !bus.stall) ? w_pc_inc : bus.pc_cur;
    w_base     = w_seq;
    w_push_c   = 1'b0;
    w_pop_c    = 1'b0;
    w_err_c    = 1'b0;
    w_ie_set_c = 1'b0;
    if (bus.halt) begin
      w_base = bus.pc_cur;
    end else if (bus.eret) begin
      w_base     = r_epc;
      w_ie_set_c = 1'b1;
    end else if (bus.ret) begin
      if (!w_ras_empty) begin
        w_base  = w_top;
        w_pop_c = 1'b1;
      end else begin
        w_err_c = 1'b1;
      end
    end else if (bus.call) begin
      w_base   = bus.target;
      w_push_c = 1'b1;
    end else if (bus.jump || bus.branch_taken) begin
      w_base = bus.target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin : state_reg
    if (reset) r_state <= S_BOOT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin : next_state
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:   w_state_nxt = S_RUN;
      S_RUN:    if (!w_irq_take && bus.halt) w_state_nxt = S_HALTED;
      S_HALTED: if (w_irq_take) w_state_nxt = S_RUN;
      default:  w_state_nxt = S_BOOT;
    endcase
  end

  always_comb begin : outputs
    w_pc_next  = bus.pc_cur;
    w_imem_req = 1'b0;
    w_irq_ack  = 1'b0;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_err_set  = 1'b0;
    w_ie_set   = 1'b0;
    w_ie_clr   = 1'b0;
    w_epc_ld   = 1'b0;
    w_epc_d    = r_epc;
    case (r_state)
      S_BOOT: w_pc_next = RESET_VECTOR;
      S_RUN: begin
        w_imem_req = 1'b1;
        // interrupt entry wins outright: no stack traffic, no halt, no eret
        if (w_irq_take) begin
          w_pc_next = IRQ_VECTOR;
          w_irq_ack = 1'b1;
          w_epc_ld  = 1'b1;
          w_epc_d   = w_base;
          w_ie_clr  = 1'b1;
        end else begin
          w_pc_next = w_base;
          w_push    = w_push_c;
          w_pop     = w_pop_c;
          w_err_set = w_err_c;
          w_ie_set  = w_ie_set_c;
        end
      end
      S_HALTED: begin
        if (w_irq_take) begin
          w_pc_next = IRQ_VECTOR;
          w_irq_ack = 1'b1;
          w_epc_ld  = 1'b1;
          w_epc_d   = w_pc_inc;
          w_ie_clr  = 1'b1;
        end
      end
      default: w_pc_next = RESET_VECTOR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin : datapath
    if (reset) begin
      r_int_en  <= 1'b1;
      r_epc     <= '0;
      r_wp      <= '0;
      r_cnt     <= '0;
      r_ras_err <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
    end else begin
      if (w_ie_clr)      r_int_en <= 1'b0;
      else if (w_ie_set) r_int_en <= 1'b1;
      if (w_epc_ld) r_epc <= w_epc_d;
      // a push into a full stack overwrites the oldest entry in the ring
      if (w_push) begin
        r_ras[r_wp] <= w_pc_inc;
        r_wp        <= r_wp + 1'b1;
        if (w_ras_full) r_ras_err <= 1'b1;
        else            r_cnt     <= r_cnt + 1'b1;
      end else if (w_pop) begin
        r_wp  <= w_top_idx;
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_err_set) r_ras_err <= 1'b1;
    end
  end

  assign bus.pc_next  = w_pc_next;
  assign bus.imem_req = w_imem_req;
  assign bus.irq_ack  = w_irq_ack;
  assign bus.epc      = r_epc;
  assign bus.ras_err  = r_ras_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a queue-based reference model predicts each
// cycle's outputs, a negedge monitor pops and compares.
module tb_pc_sequencer;
  localparam logic [15:0] RV = 16'h0100;
  localparam logic [15:0] IV = 16'h0010;
  localparam int          D  = 4;
  localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pc_sequencer_if bus();
  pc_sequencer #(.RESET_VECTOR(RV), .IRQ_VECTOR(IV), .RAS_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic [15:0] pc;
    logic [15:0] epc;
    logic        req;
    logic        ack;
    logic        err;
  } exp_t;

  typedef struct {
    logic rdy, stall, br, jmp, call, ret, irq, eret, halt;
    logic [15:0] tgt;
  } stim_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int          m_st = M_BOOT;
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] m_epc = 16'h0000;
  bit          m_ie = 1'b1;
  bit          m_err = 1'b0;
  logic [15:0] m_ras[$];

  function automatic stim_t idle();
    stim_t s;
    s = '{rdy: 1'b1, stall: 1'b0, br: 1'b0, jmp: 1'b0, call: 1'b0, ret: 1'b0,
          irq: 1'b0, eret: 1'b0, halt: 1'b0, tgt: 16'h0000};
    return s;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    int n_st, t_st;
    logic [15:0] n_epc, inc, seq, base;
    bit n_ie, n_err, t_ie, t_err;
    logic [15:0] n_ras[$];
    logic [15:0] t_ras[$];
    bus.pc_cur = m_pc;       bus.imem_ready = s.rdy; bus.stall = s.stall;
    bus.branch_taken = s.br; bus.jump = s.jmp;       bus.call = s.call;
    bus.ret = s.ret;         bus.target = s.tgt;     bus.irq = s.irq;
    bus.eret = s.eret;       bus.halt = s.halt;
    n_st = m_st; n_epc = m_epc; n_ie = m_ie; n_err = m_err; n_ras = m_ras;
    e.epc = m_epc; e.err = m_err; e.ack = 1'b0; e.req = 1'b0; e.pc = m_pc;
    inc = m_pc + 16'd1;
    if (reset) begin
      e.pc = RV; n_st = M_BOOT;
    end else if (m_st == M_BOOT) begin
      e.pc = RV; n_st = M_RUN;
    end else if (m_st == M_RUN) begin
      e.req = 1'b1;
      seq = (s.rdy && !s.stall) ? inc : m_pc;
      t_ras = m_ras; t_err = m_err; t_ie = m_ie; t_st = M_RUN;
      if (s.halt) begin
        base = m_pc; t_st = M_HALT;
      end else if (s.eret) begin
        base = m_epc; t_ie = 1'b1;
      end else if (s.ret) begin
        if (t_ras.size() > 0) base = t_ras.pop_back();
        else begin base = seq; t_err = 1'b1; end
      end else if (s.call) begin
        if (t_ras.size() == D) begin void'(t_ras.pop_front()); t_err = 1'b1; end
        t_ras.push_back(inc);
        base = s.tgt;
      end else if (s.br || s.jmp) begin
        base = s.tgt;
      end else begin
        base = seq;
      end
      if (s.irq && m_ie) begin
        e.pc = IV; e.ack = 1'b1; n_epc = base; n_ie = 1'b0;
      end else begin
        e.pc = base; n_ras = t_ras; n_err = t_err; n_ie = t_ie; n_st = t_st;
      end
    end else begin
      e.pc = m_pc;
      if (s.irq && m_ie) begin
        e.pc = IV; e.ack = 1'b1; n_epc = inc; n_ie = 1'b0; n_st = M_RUN;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    m_pc = e.pc; m_st = n_st; m_epc = n_epc; m_ie = n_ie; m_err = n_err; m_ras = n_ras;
    #1;
  endtask

  // reset asserted away from the clock edge, held for n cycles, then one BOOT cycle
  task automatic do_reset(input int n);
    reset = 1'b1;
    m_st = M_BOOT; m_ie = 1'b1; m_epc = 16'h0000; m_err = 1'b0; m_ras.delete();
    for (int i = 0; i < n; i++) apply(idle());
    reset = 1'b0;
    apply(idle());
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      chk("pc_next",  bus.pc_next, e.pc);
      chk("epc",      bus.epc, e.epc);
      chk("imem_req", {15'd0, bus.imem_req}, {15'd0, e.req});
      chk("irq_ack",  {15'd0, bus.irq_ack},  {15'd0, e.ack});
      chk("ras_err",  {15'd0, bus.ras_err},  {15'd0, e.err});
    end
  end

  function automatic bit pct(input int p);
    return ($urandom_range(99) < p);
  endfunction

  initial begin
    stim_t s;
    bus.pc_cur = '0; bus.imem_ready = 1'b0; bus.stall = 1'b0; bus.branch_taken = 1'b0;
    bus.jump = 1'b0; bus.call = 1'b0; bus.ret = 1'b0; bus.target = '0;
    bus.irq = 1'b0; bus.eret = 1'b0; bus.halt = 1'b0;
    @(posedge clk); #1;
    do_reset(2);
    repeat (3) apply(idle());

    // fetch handshake: hold at 0x0005 until ready & !stall
    s = idle(); s.jmp = 1'b1; s.tgt = 16'h0005; apply(s);
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.rdy = 1'b0; s.stall = (i % 2 == 0); apply(s);
    end
    s = idle(); s.stall = 1'b1; apply(s);
    apply(idle());

    // call / ret
    s = idle(); s.jmp = 1'b1; s.tgt = 16'h0010; apply(s);
    s = idle(); s.call = 1'b1; s.tgt = 16'h0200; apply(s);
    repeat (3) apply(idle());
    s = idle(); s.ret = 1'b1; apply(s);

    // five nested calls overflow a four-deep stack; fifth ret falls through
    for (int i = 0; i < 5; i++) begin
      s = idle(); s.call = 1'b1; s.tgt = 16'h0400 + 16'(i * 16); apply(s);
    end
    for (int i = 0; i < 5; i++) begin
      s = idle(); s.ret = 1'b1; apply(s);
    end

    // irq with jump, ignored second irq, eret, irq re-enabled
    do_reset(1);
    s = idle(); s.irq = 1'b1; s.jmp = 1'b1; s.tgt = 16'h0300; apply(s);
    s = idle(); s.irq = 1'b1; apply(s);
    s = idle(); s.eret = 1'b1; apply(s);
    s = idle(); s.irq = 1'b1; apply(s);
    s = idle(); s.eret = 1'b1; apply(s);

    // halt, ignored inputs, wake on irq
    s = idle(); s.jmp = 1'b1; s.tgt = 16'h0040; apply(s);
    s = idle(); s.halt = 1'b1; apply(s);
    s = idle(); s.jmp = 1'b1; s.tgt = 16'h1234; apply(s);
    s = idle(); s.eret = 1'b1; apply(s);
    s = idle(); s.irq = 1'b1; apply(s);
    s = idle(); s.eret = 1'b1; apply(s);

    // simultaneous call & ret, irq & halt
    s = idle(); s.call = 1'b1; s.ret = 1'b1; s.tgt = 16'h0777; apply(s);
    s = idle(); s.irq = 1'b1; s.halt = 1'b1; apply(s);
    s = idle(); s.eret = 1'b1; apply(s);

    // wrap at 16'hFFFF
    s = idle(); s.jmp = 1'b1; s.tgt = 16'hFFFF; apply(s);
    apply(idle());

    // reset mid call sequence empties the stack
    s = idle(); s.call = 1'b1; s.tgt = 16'h0500; apply(s);
    s = idle(); s.call = 1'b1; s.tgt = 16'h0600; apply(s);
    do_reset(1);
    s = idle(); s.ret = 1'b1; apply(s);
    apply(idle());

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (pct(1) && ($urandom_range(1) == 0)) do_reset($urandom_range(1, 2));
      s.rdy = pct(75);  s.stall = pct(20); s.br = pct(8);  s.jmp = pct(5);
      s.call = pct(10); s.ret = pct(10);   s.irq = pct(5); s.eret = pct(6);
      s.halt = pct(2);
      s.tgt = (pct(10)) ? 16'hFFFF : 16'($urandom);
      apply(s);
    end

    @(negedge clk); #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
